nebula_noc_responder: RTL and testbench
=======================================

NEBULA_NOC_RESPONDER -- requirements
Module: nebula_noc_responder

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the maximum number of outstanding requests, legal range 1..16.
REQ-002 Parameter RESP_DATA, default all-ones of AXI_DATA_WIDTH, SHALL be the payload value written into every response flit.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  SHALL indicate a request flit is offered.
REQ-006 req_ready  output  1  SHALL indicate a request can be accepted.
REQ-007 req_flit  input  noc_flit_t  SHALL carry the request flit.
REQ-008 resp_valid  output  1  SHALL indicate a response flit is offered.
REQ-009 resp_ready  input  1  SHALL indicate the consumer accepts the response.
REQ-010 resp_flit  output  noc_flit_t  SHALL carry the response flit.
REQ-011 lat_cfg  input  8  SHALL give the response delay in cycles, sampled per request at acceptance.
REQ-012 occupancy  output  clog2(DEPTH+1)  SHALL report stored entries.
REQ-013 stat_req_cnt, stat_resp_cnt  output  32 each  SHALL report accepted requests and responses.

Function
REQ-014 Request accepted on an edge where req_valid and req_ready are both 1; entry stores req_flit and a countdown loaded with lat_cfg.
REQ-015 req_ready SHALL be 1 exactly when occupancy < DEPTH; a same-cycle pop SHALL NOT make a full block ready.
REQ-016 Each stored entry's countdown SHALL decrement by 1 per edge while nonzero, independently of position and of backpressure.
REQ-017 Responses SHALL issue strictly in acceptance order; resp_valid = head entry valid and head countdown == 0.
REQ-018 Request accepted at edge t with lat_cfg = L SHALL, if it is head, raise resp_valid in the cycle after edge t+L; minimum latency 1 cycle (L = 0).
REQ-019 resp_flit SHALL equal the head flit with payload replaced by RESP_DATA; packet_id and all other fields echoed unchanged.
REQ-020 resp_valid and resp_flit SHALL stay stable until resp_valid and resp_ready both 1; entry popped on that edge.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; push to slot, pop from head, both in same edge.
REQ-022 Storage SHALL be a circular buffer; read and write pointers wrap from DEPTH-1 to 0.
REQ-023 Counters SHALL wrap modulo 2^32 without saturation.

Reset
REQ-024 While rst_n = 0: all entries invalid, pointers 0, occupancy 0, resp_valid 0, resp_flit all-zero, req_ready 0, stat counters 0.
REQ-025 Reset asserted mid-operation SHALL discard all pending entries with no response issued; req_ready 1 from the first cycle after rst_n deasserts.

Configuration
REQ-026 With NEBULA_RESP_STATS_EN defined, stat_req_cnt and stat_resp_cnt SHALL increment on each request and response handshake.
REQ-027 Without NEBULA_RESP_STATS_EN, both stat outputs SHALL be tied 0 and no counter flops are inferred; ports remain present.

Structure
REQ-028 noc_flit_t, AXI_DATA_WIDTH and a new resp_entry_t (flit + 8-bit countdown + valid) SHALL reside in nebula_pkg.
REQ-029 Entry storage with per-entry countdowns SHALL be one sub-module, nebula_resp_fifo; the top holds handshake, payload substitution and stats.

Verification
REQ-030 Single request packet_id=5, lat_cfg=2, resp_ready=1 -> resp_valid in 3rd cycle after acceptance, packet_id 5, payload all-ones, occupancy returns to 0.
REQ-031 Four back-to-back requests ids 1..4, lat_cfg=0, DEPTH=4, resp_ready=0 -> req_ready 0 after 4th, occupancy 4; raise resp_ready -> responses ids 1,2,3,4 on consecutive cycles.
REQ-032 Request id 7 lat_cfg=5 then id 8 lat_cfg=0 -> id 7 issued first, id 8 the following cycle (in-order).
REQ-033 resp_ready held 0 for 10 cycles with resp_valid 1 -> resp_flit unchanged each cycle; handshake on release pops exactly one entry.
REQ-034 Reset asserted with 3 entries pending -> resp_valid 0 immediately, occupancy 0, no stale response after release.
REQ-035 With NEBULA_RESP_STATS_EN, 6 requests and 6 responses -> stat_req_cnt = 6, stat_resp_cnt = 6; without macro -> both 0.

Source files
------------

// File: rtl/nebula_pkg.sv
// Shared NoC flit types and the response-entry record used by the responder.
package nebula_pkg;

    localparam int AXI_DATA_WIDTH = 32;
    localparam int LAT_W          = 8;

    typedef struct packed {
        logic [1:0]                flit_type;
        logic [3:0]                src_id;
        logic [3:0]                dst_id;
        logic [7:0]                packet_id;
        logic [AXI_DATA_WIDTH-1:0] payload;
    } noc_flit_t;

    typedef struct packed {
        noc_flit_t        flit;
        logic [LAT_W-1:0] countdown;
        logic             valid;
    } resp_entry_t;

    // Response keeps every header field of the request; only the payload changes.
    function automatic noc_flit_t make_resp(input noc_flit_t req,
                                            input logic [AXI_DATA_WIDTH-1:0] data);
        noc_flit_t r;
        r         = req;
        r.payload = data;
        return r;
    endfunction

endpackage

// File: rtl/nebula_resp_fifo.sv
// In-order circular buffer of pending responses; every stored entry counts its
// own delay down in parallel, and only the head may leave once its count is zero.
module nebula_resp_fifo
    import nebula_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  noc_flit_t        push_flit,
    input  logic [LAT_W-1:0] push_lat,
    input  logic             pop,
    output logic             head_ready,
    output noc_flit_t        head_flit,
    output logic             full,
    output logic [OCC_W-1:0] occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occ_q;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_ready = mem[rd_ptr].valid && (mem[rd_ptr].countdown == '0);
    assign head_flit  = mem[rd_ptr].flit;
    assign full       = (occ_q == OCC_W'(DEPTH));
    assign occupancy  = occ_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ_q  <= '0;
        end else begin
            // Countdowns run regardless of position or output backpressure.
            for (int i = 0; i < DEPTH; i++) begin
                if (mem[i].valid && (mem[i].countdown != '0)) begin
                    mem[i].countdown <= mem[i].countdown - LAT_W'(1);
                end
            end
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= ptr_next(rd_ptr);
            end
            // A push never targets the popped slot: push needs !full, pop needs !empty.
            if (push) begin
                mem[wr_ptr].flit      <= push_flit;
                mem[wr_ptr].countdown <= push_lat;
                mem[wr_ptr].valid     <= 1'b1;
                wr_ptr                <= ptr_next(wr_ptr);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/nebula_noc_responder.sv
// NoC responder: accepts request flits, replies in order after a per-request delay
// with the payload replaced by RESP_DATA. Define NEBULA_RESP_STATS_EN for counters.
module nebula_noc_responder
    import nebula_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [AXI_DATA_WIDTH-1:0] RESP_DATA = {AXI_DATA_WIDTH{1'b1}},
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  noc_flit_t        req_flit,
    output logic             resp_valid,
    input  logic             resp_ready,
    output noc_flit_t        resp_flit,
    input  logic [7:0]       lat_cfg,
    output logic [OCC_W-1:0] occupancy,
    output logic [31:0]      stat_req_cnt,
    output logic [31:0]      stat_resp_cnt
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1. A producer holds valid and its flit stable until that edge; ready
    // never depends on valid, and a pop in the same cycle does not free a full slot.
    logic      push;
    logic      pop;
    logic      full;
    logic      head_ready;
    noc_flit_t head_flit;

    assign req_ready  = rst_n && !full;
    assign push       = req_valid && req_ready;
    assign resp_valid = head_ready;
    assign pop        = resp_valid && resp_ready;
    assign resp_flit  = resp_valid ? make_resp(head_flit, RESP_DATA) : '0;

    nebula_resp_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_flit (req_flit),
        .push_lat  (lat_cfg),
        .pop       (pop),
        .head_ready(head_ready),
        .head_flit (head_flit),
        .full      (full),
        .occupancy (occupancy)
    );

`ifdef NEBULA_RESP_STATS_EN
    logic [31:0] req_cnt_q;
    logic [31:0] resp_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt_q  <= '0;
            resp_cnt_q <= '0;
        end else begin
            if (push) req_cnt_q  <= req_cnt_q + 32'd1;
            if (pop)  resp_cnt_q <= resp_cnt_q + 32'd1;
        end
    end

    assign stat_req_cnt  = req_cnt_q;
    assign stat_resp_cnt = resp_cnt_q;
`else
    assign stat_req_cnt  = '0;
    assign stat_resp_cnt = '0;
`endif

endmodule

// File: tb/tb_nebula_noc_responder.sv
// Self-checking bench for nebula_noc_responder: scoreboard on response flits,
// a latency table, and hand-written backpressure / ordering / reset sequences.
module tb_nebula_noc_responder;
    import nebula_pkg::*;

    localparam int DEPTH  = 4;
    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int FLIT_W = $bits(noc_flit_t);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    noc_flit_t        req_flit = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    noc_flit_t        resp_flit;
    logic [7:0]       lat_cfg = 8'd0;
    logic [OCC_W-1:0] occupancy;
    logic [31:0]      stat_req_cnt;
    logic [31:0]      stat_resp_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [FLIT_W-1:0] exp_q[$];

    typedef struct {
        logic [7:0] id;
        logic [7:0] lat;
        int         exp_lat;
    } vec_t;

    nebula_noc_responder #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_flit     (req_flit),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_flit    (resp_flit),
        .lat_cfg      (lat_cfg),
        .occupancy    (occupancy),
        .stat_req_cnt (stat_req_cnt),
        .stat_resp_cnt(stat_resp_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic noc_flit_t mk_req(input logic [7:0] id);
        noc_flit_t f;
        f.flit_type = 2'($urandom_range(0, 3));
        f.src_id    = 4'($urandom_range(0, 15));
        f.dst_id    = 4'($urandom_range(0, 15));
        f.packet_id = id;
        f.payload   = 32'($urandom);
        return f;
    endfunction

    function automatic noc_flit_t exp_resp(input noc_flit_t f);
        noc_flit_t r;
        r         = f;
        r.payload = {AXI_DATA_WIDTH{1'b1}};
        return r;
    endfunction

    // scoreboard: expect on request handshake, compare on response handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid && req_ready) exp_q.push_back(FLIT_W'(exp_resp(req_flit)));
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_flit), 64'(0));
                end else begin
                    chk("resp_flit", 64'(resp_flit), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // driver: called at posedge+1, returns at the next posedge+1
    task automatic push_req(input noc_flit_t f, input logic [7:0] l);
        req_valid = 1'b1;
        req_flit  = f;
        lat_cfg   = l;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 300);
        if (!resp_valid) chk("resp_timeout", 64'(0), 64'(1));
    endtask

    vec_t      vecs [6];
    noc_flit_t f20;
    noc_flit_t f21;
    int        n;
    logic      stale;

    initial begin
        vecs[0] = '{id: 8'd11, lat: 8'd0, exp_lat: 1};
        vecs[1] = '{id: 8'd12, lat: 8'd1, exp_lat: 2};
        vecs[2] = '{id: 8'd5,  lat: 8'd2, exp_lat: 3};
        vecs[3] = '{id: 8'd13, lat: 8'd3, exp_lat: 4};
        vecs[4] = '{id: 8'd14, lat: 8'd7, exp_lat: 8};
        vecs[5] = '{id: 8'd15, lat: 8'd0, exp_lat: 1};

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_occupancy", 64'(occupancy), 64'(0));
        chk("rst_resp_flit", 64'(resp_flit), 64'(0));
        chk("rst_stat_req", 64'(stat_req_cnt), 64'(0));
        chk("rst_stat_resp", 64'(stat_resp_cnt), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("ready_after_rst", 64'(req_ready), 64'(1));
        @(posedge clk); #1;

        // reset with three entries pending
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_req(mk_req(8'(40 + i)), 8'd0);
        @(negedge clk);
        chk("pend_occupancy", 64'(occupancy), 64'(3));
        chk("pend_resp_valid", 64'(resp_valid), 64'(1));
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_resp_valid", 64'(resp_valid), 64'(0));
        chk("midrst_occupancy", 64'(occupancy), 64'(0));
        chk("midrst_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        stale = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid) stale = 1'b1;
        end
        chk("no_stale_resp", 64'(stale), 64'(0));
        chk("post_rst_occupancy", 64'(occupancy), 64'(0));
        @(posedge clk); #1;

        // latency table, resp_ready held high
        for (int i = 0; i < 6; i++) begin
            push_req(mk_req(vecs[i].id), vecs[i].lat);
            wait_resp(n);
            chk($sformatf("lat_row%0d", i), 64'(n), 64'(vecs[i].exp_lat));
            chk($sformatf("id_row%0d", i), 64'(resp_flit.packet_id), 64'(vecs[i].id));
            chk($sformatf("payload_row%0d", i), 64'(resp_flit.payload), 64'(32'hFFFF_FFFF));
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("occ_row%0d", i), 64'(occupancy), 64'(0));
            @(posedge clk); #1;
        end

`ifdef NEBULA_RESP_STATS_EN
        chk("stat_req_cnt", 64'(stat_req_cnt), 64'(6));
        chk("stat_resp_cnt", 64'(stat_resp_cnt), 64'(6));
`else
        chk("stat_req_cnt", 64'(stat_req_cnt), 64'(0));
        chk("stat_resp_cnt", 64'(stat_resp_cnt), 64'(0));
`endif

        // fill to DEPTH with backpressure, then drain back-to-back
        resp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_req(mk_req(8'(i)), 8'd0);
        @(negedge clk);
        chk("full_req_ready", 64'(req_ready), 64'(0));
        chk("full_occupancy", 64'(occupancy), 64'(4));
        @(posedge clk); #1;
        resp_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("drain_valid%0d", i), 64'(resp_valid), 64'(1));
            chk($sformatf("drain_id%0d", i), 64'(resp_flit.packet_id), 64'(i));
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_occupancy", 64'(occupancy), 64'(0));
        @(posedge clk); #1;

        // in-order: long delay ahead of a short one
        push_req(mk_req(8'd7), 8'd5);
        push_req(mk_req(8'd8), 8'd0);
        wait_resp(n);
        chk("order_first", 64'(resp_flit.packet_id), 64'(7));
        @(negedge clk);
        chk("order_second_valid", 64'(resp_valid), 64'(1));
        chk("order_second", 64'(resp_flit.packet_id), 64'(8));
        @(posedge clk); #1;

        // backpressure stability
        resp_ready = 1'b0;
        f20 = mk_req(8'd20);
        f21 = mk_req(8'd21);
        push_req(f20, 8'd0);
        push_req(f21, 8'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("hold_valid%0d", i), 64'(resp_valid), 64'(1));
            chk($sformatf("hold_flit%0d", i), 64'(resp_flit), 64'(exp_resp(f20)));
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("release_occupancy", 64'(occupancy), 64'(1));
        chk("release_next", 64'(resp_flit), 64'(exp_resp(f21)));
        @(posedge clk); #1;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("final_occupancy", 64'(occupancy), 64'(0));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
